// File: rtl/pc_fetch_unit_if.sv
// Fetch-stage bus: instruction-memory read port plus the decode-stage
// valid/accept handshake. The fetch unit is the master of both.
interface pc_fetch_unit_if #(
   parameter int DATA_W = 16
);
   logic              mem_req;
   logic [DATA_W-1:0] mem_addr;
   logic              mem_ready;
   logic [DATA_W-1:0] mem_rdata;
   logic              instr_valid;
   logic [DATA_W-1:0] instr;
   logic [DATA_W-1:0] instr_pc;
   logic              instr_accept;

   modport master (
      output mem_req, mem_addr, instr_valid, instr, instr_pc,
      input  mem_ready, mem_rdata, instr_accept
   );

   modport slave (
      input  mem_req, mem_addr, instr_valid, instr, instr_pc,
      output mem_ready, mem_rdata, instr_accept
   );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch stage of the 16-bit CPU.
// One outstanding fetch at a time: FETCH requests a word, HOLD presents it
// to decode until accepted. A jump or branch redirect overrides everything
// except reset and discards any fetched or held word.
module pc_fetch_unit #(
   parameter int              DATA_W   = 16,
   parameter int              PC_STEP  = 2,
   parameter logic [DATA_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              jump,
   input  logic [DATA_W-1:0] jump_target,
   input  logic              branch_taken,
   input  logic [DATA_W-1:0] branch_target,
   pc_fetch_unit_if.master   bus
);

   typedef enum logic {FETCH, HOLD} state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] pc_q;
   logic [DATA_W-1:0] instr_q;
   logic [DATA_W-1:0] instr_pc_q;
   logic              instr_valid_q;

   logic              redirect;
   logic [DATA_W-1:0] next_target;
   logic              fetch_fire;
   logic              retire;

   // Redirect decode: jump wins over branch; targets are halfword aligned.
   assign redirect    = jump | branch_taken;
   assign next_target = jump ? {jump_target[DATA_W-1:1], 1'b0}
                             : {branch_target[DATA_W-1:1], 1'b0};

   // rst_n gates the request so it drops the instant reset asserts,
   // independent of the clock.
   assign bus.mem_req  = rst_n && (state_q == FETCH) && !stall && !redirect;
   assign bus.mem_addr = pc_q;
   assign fetch_fire   = bus.mem_req && bus.mem_ready;
   assign retire       = (state_q == HOLD) && bus.instr_accept && !stall && !redirect;

   assign bus.instr_valid = instr_valid_q;
   assign bus.instr       = instr_q;
   assign bus.instr_pc    = instr_pc_q;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FETCH;
      end else begin
         // NOTE: clocked state uses non-blocking assignment so every flop
         // samples the pre-edge values regardless of statement order.
         state_q <= state_d;
      end
   end

   // Next-state selection: redirect first, then the fetch/hold handshake.
   always_comb begin
      // NOTE: default first so every path assigns state_d and no latch forms.
      state_d = state_q;
      if (redirect) begin
         state_d = FETCH;
      end else begin
         case (state_q)
            FETCH:   if (fetch_fire) state_d = HOLD;
            HOLD:    if (retire)     state_d = FETCH;
            default: state_d = FETCH;
         endcase
      end
   end

   // PC and instruction output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q          <= RESET_PC;
         instr_q       <= '0;
         instr_pc_q    <= '0;
         instr_valid_q <= 1'b0;
      end else if (redirect) begin
         pc_q          <= next_target;
         instr_valid_q <= 1'b0;
      end else if (fetch_fire) begin
         instr_q       <= bus.mem_rdata;
         instr_pc_q    <= pc_q;
         instr_valid_q <= 1'b1;
         pc_q          <= pc_q + DATA_W'(PC_STEP);
      end else if (retire) begin
         instr_valid_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: sequential fetch, memory wait states,
// hold/stall behaviour, redirect priority, PC wrap and asynchronous reset.
module tb_pc_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall, jump, branch_taken;
   logic [15:0] jump_target, branch_target;

   pc_fetch_unit_if #(.DATA_W(16)) bus_a ();
   pc_fetch_unit_if #(.DATA_W(16)) bus_b ();

   // Instruction memory model: word = address ^ A5A5.
   assign bus_a.mem_rdata = bus_a.mem_addr ^ 16'hA5A5;
   assign bus_b.mem_rdata = bus_b.mem_addr ^ 16'hA5A5;

   pc_fetch_unit #(.DATA_W(16), .PC_STEP(2), .RESET_PC(16'h0000)) dut_a (
      .clk           (clk),
      .rst_n         (rst_n),
      .stall         (stall),
      .jump          (jump),
      .jump_target   (jump_target),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .bus           (bus_a)
   );

   // Second instance exercises PC wrap from the top of the address space.
   pc_fetch_unit #(.DATA_W(16), .PC_STEP(2), .RESET_PC(16'hFFFE)) dut_b (
      .clk           (clk),
      .rst_n         (rst_n),
      .stall         (1'b0),
      .jump          (1'b0),
      .jump_target   (16'h0000),
      .branch_taken  (1'b0),
      .branch_target (16'h0000),
      .bus           (bus_b)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      stall = 1'b0; jump = 1'b0; branch_taken = 1'b0;
      jump_target = 16'h0; branch_target = 16'h0;
      bus_a.mem_ready = 1'b0; bus_a.instr_accept = 1'b0;
      bus_b.mem_ready = 1'b1; bus_b.instr_accept = 1'b1;

      // Reset state, before any clock edge.
      #3;
      check("rst_req",   {15'b0, bus_a.mem_req},     16'h0);
      check("rst_valid", {15'b0, bus_a.instr_valid}, 16'h0);
      check("rst_instr", bus_a.instr,                16'h0);
      check("rst_ipc",   bus_a.instr_pc,             16'h0);
      check("rst_addr",  bus_a.mem_addr,             16'h0);
      check("rst_req_b", {15'b0, bus_b.mem_req},     16'h0);

      // Sequential fetch with memory always ready and decode always accepting.
      #9;
      rst_n = 1'b1;
      bus_a.mem_ready = 1'b1; bus_a.instr_accept = 1'b1;
      #1;
      check("seq_req0",  {15'b0, bus_a.mem_req}, 16'h1);
      check("seq_addr0", bus_a.mem_addr,         16'h0000);
      check("b_addr0",   bus_b.mem_addr,         16'hFFFE);
      step();
      check("seq_v0",    {15'b0, bus_a.instr_valid}, 16'h1);
      check("seq_i0",    bus_a.instr,                16'hA5A5);
      check("seq_pc0",   bus_a.instr_pc,             16'h0000);
      check("seq_hreq",  {15'b0, bus_a.mem_req},     16'h0);
      check("b_ipc",     bus_b.instr_pc,             16'hFFFE);
      check("b_instr",   bus_b.instr,                16'h5A5B);
      check("b_wrap",    bus_b.mem_addr,             16'h0000);
      step();
      check("seq_gap1",  {15'b0, bus_a.instr_valid}, 16'h0);
      check("seq_addr1", bus_a.mem_addr,             16'h0002);
      check("b_req1",    {15'b0, bus_b.mem_req},     16'h1);
      step();
      check("seq_i1",    bus_a.instr,    16'hA5A7);
      check("seq_pc1",   bus_a.instr_pc, 16'h0002);
      step();
      check("seq_gap2",  {15'b0, bus_a.instr_valid}, 16'h0);
      check("seq_addr2", bus_a.mem_addr,             16'h0004);
      step();
      check("seq_i2",    bus_a.instr,    16'hA5A1);
      check("seq_pc2",   bus_a.instr_pc, 16'h0004);

      // Hold without accept for 4 cycles, then accept under stall.
      bus_a.instr_accept = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         check("hold_v",   {15'b0, bus_a.instr_valid}, 16'h1);
         check("hold_i",   bus_a.instr,                16'hA5A1);
         check("hold_pc",  bus_a.instr_pc,             16'h0004);
      end
      stall = 1'b1; bus_a.instr_accept = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         check("stall_v",   {15'b0, bus_a.instr_valid}, 16'h1);
         check("stall_i",   bus_a.instr,                16'hA5A1);
         check("stall_req", {15'b0, bus_a.mem_req},     16'h0);
      end
      stall = 1'b0;
      step();
      check("accept_v",  {15'b0, bus_a.instr_valid}, 16'h0);
      check("accept_a",  bus_a.mem_addr,             16'h0006);

      // Jump to 0x0010, then three wait-state cycles.
      bus_a.instr_accept = 1'b0; bus_a.mem_ready = 1'b0;
      jump = 1'b1; jump_target = 16'h0010;
      #1;
      check("jmp_req",   {15'b0, bus_a.mem_req}, 16'h0);
      step();
      jump = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         check("wait_req",  {15'b0, bus_a.mem_req},     16'h1);
         check("wait_addr", bus_a.mem_addr,             16'h0010);
         check("wait_v",    {15'b0, bus_a.instr_valid}, 16'h0);
         if (i < 2) step();
      end
      bus_a.mem_ready = 1'b1;
      step();
      check("wait_ipc",  bus_a.instr_pc,             16'h0010);
      check("wait_i",    bus_a.instr,                16'hA5B5);
      check("wait_pc",   bus_a.mem_addr,             16'h0012);

      // Jump and branch together while holding with accept: jump wins, drop.
      jump = 1'b1; jump_target = 16'h1235;
      branch_taken = 1'b1; branch_target = 16'h4000;
      bus_a.instr_accept = 1'b1;
      #1;
      check("both_req",  {15'b0, bus_a.mem_req}, 16'h0);
      step();
      check("both_v",    {15'b0, bus_a.instr_valid}, 16'h0);
      check("both_addr", bus_a.mem_addr,             16'h1234);
      // Same redirect again in FETCH with mem_ready high: word discarded.
      step();
      check("disc_v",    {15'b0, bus_a.instr_valid}, 16'h0);
      check("disc_ipc",  bus_a.instr_pc,             16'h0010);
      check("disc_addr", bus_a.mem_addr,             16'h1234);
      jump = 1'b0; branch_taken = 1'b0; bus_a.instr_accept = 1'b0;
      #1;
      check("tgt_req",   {15'b0, bus_a.mem_req}, 16'h1);
      step();
      check("tgt_ipc",   bus_a.instr_pc, 16'h1234);
      check("tgt_i",     bus_a.instr,    16'hB791);

      // Branch under stall while holding: applied immediately.
      stall = 1'b1; branch_taken = 1'b1; branch_target = 16'h0801;
      step();
      branch_taken = 1'b0;
      #1;
      check("sbr_v",     {15'b0, bus_a.instr_valid}, 16'h0);
      check("sbr_addr",  bus_a.mem_addr,             16'h0800);
      check("sbr_req",   {15'b0, bus_a.mem_req},     16'h0);
      stall = 1'b0;
      #1;
      check("sbr_req2",  {15'b0, bus_a.mem_req}, 16'h1);
      step();
      check("sbr_ipc",   bus_a.instr_pc,             16'h0800);
      check("sbr_hv",    {15'b0, bus_a.instr_valid}, 16'h1);

      // Asynchronous reset pulse mid-HOLD, between clock edges.
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_v",    {15'b0, bus_a.instr_valid}, 16'h0);
      check("arst_req",  {15'b0, bus_a.mem_req},     16'h0);
      check("arst_i",    bus_a.instr,                16'h0);
      check("arst_ipc",  bus_a.instr_pc,             16'h0);
      check("arst_addr", bus_a.mem_addr,             16'h0000);
      #2;
      rst_n = 1'b1;
      #1;
      check("rel_req",   {15'b0, bus_a.mem_req}, 16'h1);
      check("rel_addr",  bus_a.mem_addr,         16'h0000);
      step();
      check("rel_ipc",   bus_a.instr_pc, 16'h0000);
      check("rel_i",     bus_a.instr,    16'hA5A5);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
